// File: rtl/blk_fetch_ctrl.sv
// Block fetch controller: takes block indices from an address generator, issues
// one line-read per block row, and counts consumer-completed blocks per frame.
module blk_fetch_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int BLK_SIZE   = 32,
    parameter int COLUMNS    = IMG_WIDTH / BLK_SIZE,
    parameter int ROWS       = IMG_HEIGHT / BLK_SIZE,
    parameter int NBLK       = COLUMNS * ROWS,
    parameter int IDX_W      = $clog2(NBLK),
    parameter int MEM_AW     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_gen_req,
    input  logic              i_gen_vld,
    input  logic [IDX_W-1:0]  i_gen_adr,
    input  logic              i_gen_eof,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_adr,
    input  logic              i_mem_ack,
    output logic              o_blk_start,
    output logic [IDX_W-1:0]  o_blk_idx,
    input  logic              i_blk_done,
    output logic [IDX_W-1:0]  o_blk_cnt,
    output logic              o_frame_done,
    output logic              o_err
);

    localparam int LINE_W = (BLK_SIZE > 1) ? $clog2(BLK_SIZE) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(BLK_SIZE - 1);
    localparam logic [IDX_W1-1:0] NBLK_C      = IDX_W1'(NBLK);
    localparam logic [IDX_W-1:0]  COLUMNS_C   = IDX_W'(COLUMNS);
    localparam logic [MEM_AW-1:0] ROW_STRIDE  = MEM_AW'(BLK_SIZE * IMG_WIDTH);
    localparam logic [MEM_AW-1:0] COL_STRIDE  = MEM_AW'(BLK_SIZE);
    localparam logic [MEM_AW-1:0] LINE_STRIDE = MEM_AW'(IMG_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_ADR  = 3'd2,
        ST_BURST     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                gen_req_r, gen_req_nxt_s;
    logic                mem_req_r, mem_req_nxt_s;
    logic [MEM_AW-1:0]   mem_adr_r, mem_adr_nxt_s;
    logic                blk_start_r, blk_start_nxt_s;
    logic [IDX_W-1:0]    blk_idx_r, blk_idx_nxt_s;
    logic [IDX_W-1:0]    blk_cnt_r, blk_cnt_nxt_s;
    logic                frame_done_r, frame_done_nxt_s;
    logic                err_r, err_nxt_s;
    logic [LINE_W-1:0]   line_r, line_nxt_s;
    logic                done_lat_r, done_lat_nxt_s;

    logic [IDX_W-1:0]    bx_s, by_s;
    logic [MEM_AW-1:0]   base_adr_s;
    logic                idx_ok_s;
    logic                abort_s;

    assign abort_s = i_abort && (state_r != ST_IDLE);

    // Block column/row split and top-left pixel address of the offered index.
    always_comb begin
        bx_s       = i_gen_adr % COLUMNS_C;
        by_s       = i_gen_adr / COLUMNS_C;
        base_adr_s = MEM_AW'(by_s) * ROW_STRIDE + MEM_AW'(bx_s) * COL_STRIDE;
        idx_ok_s   = {1'b0, i_gen_adr} < NBLK_C;
    end

    // Next-state and next-output logic; abort overrides every transition.
    always_comb begin
        state_nxt_s     = state_r;
        mem_req_nxt_s   = mem_req_r;
        mem_adr_nxt_s   = mem_adr_r;
        blk_idx_nxt_s   = blk_idx_r;
        blk_cnt_nxt_s   = blk_cnt_r;
        err_nxt_s       = err_r;
        line_nxt_s      = line_r;
        done_lat_nxt_s  = done_lat_r;
        blk_start_nxt_s = 1'b0;

        if (abort_s) begin
            state_nxt_s    = ST_IDLE;
            mem_req_nxt_s  = 1'b0;
            done_lat_nxt_s = 1'b0;
            line_nxt_s     = {LINE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        state_nxt_s   = ST_REQ;
                        blk_cnt_nxt_s = {IDX_W{1'b0}};
                        err_nxt_s     = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_nxt_s = ST_WAIT_ADR;
                end
                ST_WAIT_ADR: begin
                    if (i_gen_vld) begin
                        if (idx_ok_s) begin
                            mem_adr_nxt_s   = base_adr_s;
                            blk_idx_nxt_s   = i_gen_adr;
                            mem_req_nxt_s   = 1'b1;
                            blk_start_nxt_s = 1'b1;
                            line_nxt_s      = {LINE_W{1'b0}};
                            state_nxt_s     = ST_BURST;
                        end else begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = ST_REQ;
                        end
                    end else if (i_gen_eof) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT_ADR;
                    end
                end
                ST_BURST: begin
                    if (i_blk_done) begin
                        done_lat_nxt_s = 1'b1;
                    end else begin
                        done_lat_nxt_s = done_lat_r;
                    end
                    // Request stays up across lines so consecutive acks stream one line per cycle.
                    if (i_mem_ack) begin
                        mem_adr_nxt_s = mem_adr_r + LINE_STRIDE;
                        if (line_r == LAST_LINE) begin
                            mem_req_nxt_s = 1'b0;
                            line_nxt_s    = {LINE_W{1'b0}};
                            state_nxt_s   = ST_WAIT_DONE;
                        end else begin
                            line_nxt_s = line_r + LINE_W'(1);
                        end
                    end else begin
                        mem_req_nxt_s = 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_lat_r || i_blk_done) begin
                        done_lat_nxt_s = 1'b0;
                        blk_cnt_nxt_s  = blk_cnt_r + IDX_W'(1);
                        state_nxt_s    = ST_REQ;
                    end else begin
                        state_nxt_s = ST_WAIT_DONE;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    mem_req_nxt_s = 1'b0;
                end
            endcase
        end

        gen_req_nxt_s    = (state_nxt_s == ST_REQ);
        frame_done_nxt_s = (state_nxt_s == ST_DONE);
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
    end

    // State and registered outputs; reset is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            gen_req_r    <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_adr_r    <= {MEM_AW{1'b0}};
            blk_start_r  <= 1'b0;
            blk_idx_r    <= {IDX_W{1'b0}};
            blk_cnt_r    <= {IDX_W{1'b0}};
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            line_r       <= {LINE_W{1'b0}};
            done_lat_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= busy_nxt_s;
            gen_req_r    <= gen_req_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_adr_r    <= mem_adr_nxt_s;
            blk_start_r  <= blk_start_nxt_s;
            blk_idx_r    <= blk_idx_nxt_s;
            blk_cnt_r    <= blk_cnt_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            err_r        <= err_nxt_s;
            line_r       <= line_nxt_s;
            done_lat_r   <= done_lat_nxt_s;
        end
    end

    assign o_busy       = busy_r;
    assign o_gen_req    = gen_req_r;
    assign o_mem_req    = mem_req_r;
    assign o_mem_adr    = mem_adr_r;
    assign o_blk_start  = blk_start_r;
    assign o_blk_idx    = blk_idx_r;
    assign o_blk_cnt    = blk_cnt_r;
    assign o_frame_done = frame_done_r;
    assign o_err        = err_r;

endmodule

// File: doc/blk_fetch_ctrl.md
BLK_FETCH_CTRL -- requirements
Module: blk_fetch_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- IMG_WIDTH, 640, image width in pixels
- IMG_HEIGHT, 480, image height in pixels
- BLK_SIZE, 32, block edge in pixels
- COLUMNS, IMG_WIDTH/BLK_SIZE, blocks per row
- ROWS, IMG_HEIGHT/BLK_SIZE, blocks per column
- NBLK, COLUMNS*ROWS, blocks per frame
- IDX_W, clog2(NBLK), block index width (9)
- MEM_AW, clog2(IMG_WIDTH*IMG_HEIGHT), pixel address width (19)
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- i_start  in  1  pulse, begin frame; ignored unless IDLE
- i_abort  in  1  level, cancel frame
- o_busy  out  1  high in every state except IDLE
- o_gen_req  out  1  one-cycle request to address generator for the next block index
- i_gen_vld  in  1  i_gen_adr valid
- i_gen_adr  in  IDX_W  block index, raster order
- i_gen_eof  in  1  generator has no more indices
- o_mem_req  out  1  line-read request
- o_mem_adr  out  MEM_AW  pixel address of line start
- i_mem_ack  in  1  request accepted
- o_blk_start  out  1  one-cycle pulse, block fetch begins
- o_blk_idx  out  IDX_W  index of current block, held until next block
- i_blk_done  in  1  pulse, consumer finished the block
- o_blk_cnt  out  IDX_W  blocks completed this frame
- o_frame_done  out  1  one-cycle pulse, frame complete
- o_err  out  1  sticky, out-of-range index received

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT_ADR, BURST, WAIT_DONE and DONE; all outputs SHALL be registered.
REQ-004 IDLE -> REQ on i_start; i_start SHALL clear o_blk_cnt and o_err.
REQ-005 REQ SHALL drive o_gen_req high for exactly one cycle, then go to WAIT_ADR.
REQ-006 WAIT_ADR with i_gen_vld=1 and i_gen_adr<NBLK SHALL:
- load bx=idx mod COLUMNS and by=idx/COLUMNS;
- set o_mem_adr=by*BLK_SIZE*IMG_WIDTH+bx*BLK_SIZE and o_blk_idx=idx;
- raise o_mem_req and pulse o_blk_start;
- enter BURST on the next cycle.
REQ-007 WAIT_ADR with i_gen_vld=1 and i_gen_adr>=NBLK SHALL set o_err, skip the block (no memory request) and return to REQ.
REQ-008 WAIT_ADR with i_gen_vld=0 and i_gen_eof=1 SHALL go to DONE; i_gen_vld has priority over i_gen_eof.
REQ-009 BURST memory requests SHALL follow these rules:
- o_mem_req and o_mem_adr stay stable until i_mem_ack is sampled high.
- Each ack advances o_mem_adr by IMG_WIDTH and increments a line counter (0..BLK_SIZE-1).
- o_mem_req stays high between lines, so back-to-back acks give one line per cycle.
REQ-010 On the BLK_SIZE-th ack, o_mem_req SHALL drop in the same update and the FSM SHALL go to WAIT_DONE.
REQ-011 i_blk_done SHALL be latched in either BURST or WAIT_DONE. In WAIT_DONE with the latch set or i_blk_done=1, the block SHALL complete:
- clear the latch and increment o_blk_cnt;
- go to REQ.
REQ-012 DONE SHALL pulse o_frame_done for one cycle, then go to IDLE with o_blk_cnt held.
REQ-013 i_abort=1 in any non-IDLE state SHALL:
- force IDLE on the next cycle and drop o_mem_req and o_gen_req;
- clear the done latch;
- not pulse o_frame_done.
REQ-014 i_abort SHALL take priority over all other transitions; o_blk_cnt and o_err SHALL be held through an abort.
REQ-015 Address arithmetic SHALL be unsigned, MEM_AW wide and non-wrapping for valid indices.

Reset
REQ-016 While rst_n=0 at a clock edge:
- the FSM SHALL enter IDLE;
- all outputs, o_blk_cnt and o_err SHALL be 0, o_mem_adr and o_blk_idx 0;
- the line counter and done latch SHALL be 0.
REQ-017 Reset SHALL take priority over i_abort and i_start, including mid-burst.

Verification
REQ-018 Start, index 0, ack tied high:
- o_gen_req occurs 1 cycle after i_start.
- Lines read are 0,640,...,19840 on 32 consecutive cycles.
- i_blk_done then gives o_blk_cnt=1.
REQ-019 Index 21 -> base 20512. Index 299 -> first line 287328, last line 307168.
REQ-020 Ack withheld 5 cycles on line 3 -> o_mem_adr holds 1920 for all 5 cycles, with no skipped or duplicated line.
REQ-021 i_blk_done pulsed during BURST -> latched, no wait in WAIT_DONE. Index 300 -> o_err=1, no o_mem_req, next o_gen_req issued.
REQ-022 Full 300-index frame then i_gen_eof -> one o_frame_done pulse with o_blk_cnt=300.
REQ-023 Abort mid-burst (line 10) -> IDLE next cycle, o_mem_req=0, no o_frame_done. rst_n low mid-burst -> all outputs 0 on the next cycle.
